// File: rtl/urisc_pkg.sv
// Shared uRISC types for the memory stage: FSM states and the
// execute->memory and memory->writeback bundles.
package urisc_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 ld;
        logic                 st;
        logic [DATA_W-1:0]    addr;
        logic [DATA_W-1:0]    st_data;
        logic [DATA_W-1:0]    result;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_wr;
    } ixmem_bundle_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } memwb_bundle_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Cycle counter bounding an outstanding memory transaction; expired_o is
// high during the last permitted cycle.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Flag is precomputed from the next count so it lines up with cnt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == LAST);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/mem_stage.sv
// uRISC memory stage: issues loads/stores over req/gnt/rvalid, passes ALU
// results through, and drives a registered writeback bundle.
module mem_stage #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_ixmem_p1,
    input  logic                            ld_ixmem_p1,
    input  logic                            st_ixmem_p1,
    input  logic [DATA_W-1:0]               addr_ixmem_p1,
    input  logic [DATA_W-1:0]               st_data_ixmem_p1,
    input  logic [DATA_W-1:0]               result_ixmem_p1,
    input  logic [urisc_pkg::REG_IDX_W-1:0] rd_ixmem_p1,
    input  logic                            reg_wr_ixmem_p1,
    output logic                            stall_memix_p1,
    output logic                            dmem_req_p1,
    output logic                            dmem_we_p1,
    output logic [DATA_W-1:0]               dmem_addr_p1,
    output logic [DATA_W-1:0]               dmem_wdata_p1,
    input  logic                            dmem_gnt_p1,
    input  logic                            dmem_rvalid_p1,
    input  logic [DATA_W-1:0]               dmem_rdata_p1,
    output logic                            wb_valid_memwb_p1,
    output logic [urisc_pkg::REG_IDX_W-1:0] wb_rd_memwb_p1,
    output logic [DATA_W-1:0]               wb_data_memwb_p1,
    output logic                            err_p1
);

    import urisc_pkg::*;

    ixmem_bundle_t          ix;
    mem_state_t             state_q, state_d;
    logic [DATA_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic [REG_IDX_W-1:0]   rd_q, rd_d;
    logic                   err_q, err_d;
    logic                   stall_q, req_q;
    memwb_bundle_t          cmp_q, cmp_d;
    memwb_bundle_t          wb_q;
    logic                   cnt_clr, cnt_en, tmo_expired;

    always_comb begin
        ix.valid   = valid_ixmem_p1;
        ix.ld      = ld_ixmem_p1;
        ix.st      = st_ixmem_p1;
        ix.addr    = addr_ixmem_p1;
        ix.st_data = st_data_ixmem_p1;
        ix.result  = result_ixmem_p1;
        ix.rd      = rd_ixmem_p1;
        ix.reg_wr  = reg_wr_ixmem_p1;
    end

    mem_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clr),
        .enable_i  (cnt_en),
        .expired_o (tmo_expired)
    );

    // Next-state: cmp_d holds a completed result that reaches wb one cycle later.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rd_d    = rd_q;
        err_d   = err_q;
        cmp_d   = '0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ix.valid) begin
                    if (ix.ld && ix.st) begin
                        err_d = 1'b1;
                    end else if (ix.ld || ix.st) begin
                        if (ix.addr[0]) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = REQ;
                            addr_d  = ix.addr;
                            wdata_d = ix.st_data;
                            we_d    = ix.st;
                            rd_d    = ix.rd;
                            cnt_clr = 1'b1;
                        end
                    end else begin
                        cmp_d.valid = ix.reg_wr;
                        cmp_d.rd    = ix.rd;
                        cmp_d.data  = ix.result;
                    end
                end
            end
            REQ: begin
                cnt_en = 1'b1;
                if (dmem_gnt_p1 && we_q) begin
                    state_d = IDLE;
                end else if (dmem_gnt_p1 && dmem_rvalid_p1) begin
                    state_d    = IDLE;
                    cmp_d.valid = 1'b1;
                    cmp_d.rd    = rd_q;
                    cmp_d.data  = dmem_rdata_p1;
                end else if (tmo_expired) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (dmem_gnt_p1) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (dmem_rvalid_p1) begin
                    state_d     = IDLE;
                    cmp_d.valid = 1'b1;
                    cmp_d.rd    = rd_q;
                    cmp_d.data  = dmem_rdata_p1;
                end else if (tmo_expired) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            req_q   <= 1'b0;
            cmp_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            stall_q  <= (state_d != IDLE);
            req_q    <= (state_d == REQ);
            cmp_q    <= cmp_d;
            wb_q.valid <= cmp_q.valid;
            if (cmp_q.valid) begin
                wb_q.rd   <= cmp_q.rd;
                wb_q.data <= cmp_q.data;
            end
        end
    end

    assign stall_memix_p1    = stall_q;
    assign dmem_req_p1       = req_q;
    assign dmem_we_p1        = we_q;
    assign dmem_addr_p1      = addr_q;
    assign dmem_wdata_p1     = wdata_q;
    assign wb_valid_memwb_p1 = wb_q.valid;
    assign wb_rd_memwb_p1    = wb_q.rd;
    assign wb_data_memwb_p1  = wb_q.data;
    assign err_p1            = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written corner sequences
// and a randomized run, all checked against a transaction-level model.
module tb_mem_stage;

    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_ixmem_p1, ld_ixmem_p1, st_ixmem_p1, reg_wr_ixmem_p1;
    logic [DW-1:0] addr_ixmem_p1, st_data_ixmem_p1, result_ixmem_p1;
    logic [2:0]    rd_ixmem_p1;
    logic          stall_memix_p1, dmem_req_p1, dmem_we_p1;
    logic [DW-1:0] dmem_addr_p1, dmem_wdata_p1;
    logic          dmem_gnt_p1, dmem_rvalid_p1;
    logic [DW-1:0] dmem_rdata_p1;
    logic          wb_valid_memwb_p1, err_p1;
    logic [2:0]    wb_rd_memwb_p1;
    logic [DW-1:0] wb_data_memwb_p1;

    mem_stage #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_ixmem_p1    (valid_ixmem_p1),
        .ld_ixmem_p1       (ld_ixmem_p1),
        .st_ixmem_p1       (st_ixmem_p1),
        .addr_ixmem_p1     (addr_ixmem_p1),
        .st_data_ixmem_p1  (st_data_ixmem_p1),
        .result_ixmem_p1   (result_ixmem_p1),
        .rd_ixmem_p1       (rd_ixmem_p1),
        .reg_wr_ixmem_p1   (reg_wr_ixmem_p1),
        .stall_memix_p1    (stall_memix_p1),
        .dmem_req_p1       (dmem_req_p1),
        .dmem_we_p1        (dmem_we_p1),
        .dmem_addr_p1      (dmem_addr_p1),
        .dmem_wdata_p1     (dmem_wdata_p1),
        .dmem_gnt_p1       (dmem_gnt_p1),
        .dmem_rvalid_p1    (dmem_rvalid_p1),
        .dmem_rdata_p1     (dmem_rdata_p1),
        .wb_valid_memwb_p1 (wb_valid_memwb_p1),
        .wb_rd_memwb_p1    (wb_rd_memwb_p1),
        .wb_data_memwb_p1  (wb_data_memwb_p1),
        .err_p1            (err_p1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding access, age in cycles,
    // and a queue of writebacks scheduled for a given edge number.
    typedef struct {
        int         due;
        logic [2:0] rd;
        logic [15:0] data;
    } wb_t;

    wb_t         wbq[$];
    int          ecount = 0;
    bit          m_busy, m_store, m_granted, m_err;
    int          m_age;
    logic [15:0] m_addr, m_wdata, m_last_data;
    logic [2:0]  m_rd, m_last_rd;

    task automatic model_edge();
        bit done;
        if (rst) begin
            m_busy = 0; m_store = 0; m_granted = 0; m_err = 0; m_age = 0;
            m_addr = '0; m_wdata = '0; m_rd = '0;
            m_last_rd = '0; m_last_data = '0;
            wbq.delete();
        end else if (!m_busy) begin
            if (valid_ixmem_p1) begin
                if (ld_ixmem_p1 && st_ixmem_p1) begin
                    m_err = 1;
                end else if (ld_ixmem_p1 || st_ixmem_p1) begin
                    if (addr_ixmem_p1[0]) begin
                        m_err = 1;
                    end else begin
                        m_busy = 1; m_store = st_ixmem_p1; m_granted = 0; m_age = 0;
                        m_addr = addr_ixmem_p1; m_wdata = st_data_ixmem_p1; m_rd = rd_ixmem_p1;
                    end
                end else if (reg_wr_ixmem_p1) begin
                    wbq.push_back('{ecount + 1, rd_ixmem_p1, result_ixmem_p1});
                end
            end
        end else begin
            done = 0;
            m_age++;
            if (!m_granted && dmem_gnt_p1) begin
                if (m_store) begin
                    done = 1;
                end else if (dmem_rvalid_p1) begin
                    wbq.push_back('{ecount + 1, m_rd, dmem_rdata_p1});
                    done = 1;
                end else begin
                    m_granted = 1;
                end
            end else if (m_granted && dmem_rvalid_p1) begin
                wbq.push_back('{ecount + 1, m_rd, dmem_rdata_p1});
                done = 1;
            end
            if (done) begin
                m_busy = 0; m_granted = 0;
            end else if (m_age >= int'(TMO)) begin
                m_busy = 0; m_granted = 0; m_err = 1;
            end
        end
    endtask

    task automatic cycle_and_check(input string tag);
        logic exp_wbv;
        logic exp_req;
        ecount++;
        model_edge();
        @(posedge clk);
        #1;
        exp_wbv = 1'b0;
        if (wbq.size() > 0 && wbq[0].due == ecount) begin
            exp_wbv     = 1'b1;
            m_last_rd   = wbq[0].rd;
            m_last_data = wbq[0].data;
            wbq.delete(0);
        end
        exp_req = m_busy && !m_granted;
        check($sformatf("%s.stall", tag), 32'(stall_memix_p1), 32'(m_busy));
        check($sformatf("%s.req", tag), 32'(dmem_req_p1), 32'(exp_req));
        if (exp_req) begin
            check($sformatf("%s.we", tag), 32'(dmem_we_p1), 32'(m_store));
            check($sformatf("%s.addr", tag), 32'(dmem_addr_p1), 32'(m_addr));
            check($sformatf("%s.wdata", tag), 32'(dmem_wdata_p1), 32'(m_wdata));
        end
        check($sformatf("%s.err", tag), 32'(err_p1), 32'(m_err));
        check($sformatf("%s.wb_valid", tag), 32'(wb_valid_memwb_p1), 32'(exp_wbv));
        check($sformatf("%s.wb_rd", tag), 32'(wb_rd_memwb_p1), 32'(m_last_rd));
        check($sformatf("%s.wb_data", tag), 32'(wb_data_memwb_p1), 32'(m_last_data));
    endtask

    task automatic drive(input logic v, input logic l, input logic s, input logic [15:0] a,
                         input logic [15:0] sd, input logic [15:0] res, input logic [2:0] r,
                         input logic rw);
        valid_ixmem_p1 = v; ld_ixmem_p1 = l; st_ixmem_p1 = s; addr_ixmem_p1 = a;
        st_data_ixmem_p1 = sd; result_ixmem_p1 = res; rd_ixmem_p1 = r; reg_wr_ixmem_p1 = rw;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);
        dmem_gnt_p1 = 1'b0; dmem_rvalid_p1 = 1'b0; dmem_rdata_p1 = '0;
        cycle_and_check("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        ld, st;
        logic [15:0] addr, sdata, result;
        logic [2:0]  rd;
        logic        reg_wr;
        int          gnt_dly, rv_dly;
        logic [15:0] rdata;
        int          exp_req, exp_stall, exp_wb, exp_lat;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int          req_n, stall_n, wb_n, lat, req_seen, wait_n;
        bit          gnt_done;
        logic [15:0] wb_d;
        req_n = 0; stall_n = 0; wb_n = 0; lat = -1; req_seen = 0; wait_n = 0;
        gnt_done = 0; wb_d = '0;
        do_reset();
        drive(1'b1, v.ld, v.st, v.addr, v.sdata, v.result, v.rd, v.reg_wr);
        for (int c = 0; c < 12; c++) begin
            dmem_gnt_p1 = 1'b0; dmem_rvalid_p1 = 1'b0; dmem_rdata_p1 = 16'h0BAD;
            if (gnt_done && !v.st) begin
                wait_n++;
                if (wait_n == v.rv_dly) begin dmem_rvalid_p1 = 1'b1; dmem_rdata_p1 = v.rdata; end
            end
            if (dmem_req_p1 && !gnt_done) begin
                if (req_seen == v.gnt_dly) begin
                    dmem_gnt_p1 = 1'b1;
                    gnt_done    = 1;
                    if (!v.st && v.rv_dly == 0) begin
                        dmem_rvalid_p1 = 1'b1; dmem_rdata_p1 = v.rdata;
                    end
                end
                req_seen++;
            end
            cycle_and_check(v.name);
            valid_ixmem_p1 = 1'b0;
            if (stall_memix_p1) stall_n++;
            if (dmem_req_p1) req_n++;
            if (wb_valid_memwb_p1) begin wb_n++; lat = c; wb_d = wb_data_memwb_p1; end
        end
        check($sformatf("%s.req_cycles", v.name), 32'(req_n), 32'(v.exp_req));
        check($sformatf("%s.stall_cycles", v.name), 32'(stall_n), 32'(v.exp_stall));
        check($sformatf("%s.wb_count", v.name), 32'(wb_n), 32'(v.exp_wb));
        check($sformatf("%s.wb_latency", v.name), 32'(lat), 32'(v.exp_lat));
        check($sformatf("%s.wb_value", v.name), 32'(wb_d), 32'(v.exp_data));
        check($sformatf("%s.err_final", v.name), 32'(err_p1), 32'(v.exp_err));
    endtask

    task automatic run_timeout(input bit grant_it, input string tag);
        int stall_n, wb_n;
        bit seen_gnt;
        stall_n = 0; wb_n = 0; seen_gnt = 0;
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0, 16'h0, 3'd4, 1'b1);
        for (int c = 0; c < 200; c++) begin
            dmem_gnt_p1    = grant_it && dmem_req_p1 && !seen_gnt;
            dmem_rvalid_p1 = 1'b0;
            if (dmem_gnt_p1) seen_gnt = 1;
            cycle_and_check(tag);
            valid_ixmem_p1 = 1'b0;
            if (stall_memix_p1) stall_n++;
            if (wb_valid_memwb_p1) wb_n++;
            if (!stall_memix_p1 && c > 0) break;
        end
        check($sformatf("%s.stall_cycles", tag), 32'(stall_n), 32'(TMO));
        check($sformatf("%s.err", tag), 32'(err_p1), 32'd1);
        for (int c = 0; c < 3; c++) begin
            dmem_gnt_p1 = 1'b1; dmem_rvalid_p1 = 1'b1; dmem_rdata_p1 = 16'hDEAD;
            cycle_and_check($sformatf("%s.late", tag));
            if (wb_valid_memwb_p1) wb_n++;
        end
        dmem_gnt_p1 = 1'b0; dmem_rvalid_p1 = 1'b0;
        cycle_and_check($sformatf("%s.late", tag));
        if (wb_valid_memwb_p1) wb_n++;
        check($sformatf("%s.wb_count", tag), 32'(wb_n), 32'd0);
        check($sformatf("%s.idle_req", tag), 32'(dmem_req_p1), 32'd0);
    endtask

    initial begin
        int k;
        //            name      ld    st    addr      sdata     result    rd    rw   gd rv rdata     req stl wb lat data      err
        vecs[0] = '{"alu",     1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 3'd3, 1'b1, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h1234, 1'b0};
        vecs[1] = '{"alu_nowr",1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5555, 3'd1, 1'b0, 0, 0, 16'h0000, 0, 0, 0, -1, 16'h0000, 1'b0};
        vecs[2] = '{"ld_slow", 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 3'd5, 1'b1, 2, 1, 16'hBEEF, 3, 4, 1, 5, 16'hBEEF, 1'b0};
        vecs[3] = '{"ld_fast", 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 3'd7, 1'b1, 0, 1, 16'h1357, 1, 2, 1, 3, 16'h1357, 1'b0};
        vecs[4] = '{"ld_same", 1'b1, 1'b0, 16'h0102, 16'h0000, 16'h0000, 3'd2, 1'b1, 0, 0, 16'h2468, 1, 1, 1, 2, 16'h2468, 1'b0};
        vecs[5] = '{"st",      1'b0, 1'b1, 16'h0010, 16'hA5A5, 16'h0000, 3'd0, 1'b0, 0, 0, 16'h0000, 1, 1, 0, -1, 16'h0000, 1'b0};
        vecs[6] = '{"ld_misal",1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000, 3'd4, 1'b1, 0, 1, 16'h7777, 0, 0, 0, -1, 16'h0000, 1'b1};
        vecs[7] = '{"ld_st",   1'b1, 1'b1, 16'h0020, 16'h1111, 16'h0000, 3'd4, 1'b1, 0, 1, 16'h7777, 0, 0, 0, -1, 16'h0000, 1'b1};
        vecs[8] = '{"st_misal",1'b0, 1'b1, 16'h0013, 16'h2222, 16'h0000, 3'd0, 1'b0, 0, 0, 16'h0000, 0, 0, 0, -1, 16'h0000, 1'b1};

        do_reset();
        check("rst.stall", 32'(stall_memix_p1), 32'd0);
        check("rst.req", 32'(dmem_req_p1), 32'd0);
        check("rst.addr", 32'(dmem_addr_p1), 32'd0);
        check("rst.wb_valid", 32'(wb_valid_memwb_p1), 32'd0);
        check("rst.err", 32'(err_p1), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Misaligned access sets err but the following ALU op still writes back.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0, 16'h0, 3'd6, 1'b1);
        cycle_and_check("misal");
        check("misal.err", 32'(err_p1), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0F0F, 3'd2, 1'b1);
        cycle_and_check("misal_alu");
        valid_ixmem_p1 = 1'b0;
        cycle_and_check("misal_alu");
        check("misal_alu.wb_valid", 32'(wb_valid_memwb_p1), 32'd1);
        check("misal_alu.wb_data", 32'(wb_data_memwb_p1), 32'h0F0F);
        check("misal_alu.err_sticky", 32'(err_p1), 32'd1);

        run_timeout(1'b0, "tmo_req");
        run_timeout(1'b1, "tmo_wait");

        // Reset while waiting for read data drops the pending writeback and err.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 16'h0007, 16'h0, 16'h0, 3'd0, 1'b0);
        cycle_and_check("rstwait");
        drive(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0, 16'h0, 3'd6, 1'b1);
        cycle_and_check("rstwait");
        valid_ixmem_p1 = 1'b0;
        dmem_gnt_p1 = 1'b1;
        cycle_and_check("rstwait");
        dmem_gnt_p1 = 1'b0;
        check("rstwait.in_wait_stall", 32'(stall_memix_p1), 32'd1);
        check("rstwait.in_wait_req", 32'(dmem_req_p1), 32'd0);
        rst = 1'b1; dmem_rvalid_p1 = 1'b1; dmem_rdata_p1 = 16'hCAFE;
        cycle_and_check("rstwait");
        rst = 1'b0; dmem_rvalid_p1 = 1'b0;
        check("rstwait.stall", 32'(stall_memix_p1), 32'd0);
        check("rstwait.req", 32'(dmem_req_p1), 32'd0);
        check("rstwait.wb_valid", 32'(wb_valid_memwb_p1), 32'd0);
        check("rstwait.err", 32'(err_p1), 32'd0);
        cycle_and_check("rstwait");
        check("rstwait.no_late_wb", 32'(wb_valid_memwb_p1), 32'd0);

        // Randomized traffic with a randomly responding memory.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!m_busy) begin
                k = $urandom_range(0, 15);
                valid_ixmem_p1   = ($urandom_range(0, 3) != 0);
                ld_ixmem_p1      = (k < 5) || (k == 15);
                st_ixmem_p1      = (k >= 5 && k < 9) || (k == 15);
                addr_ixmem_p1    = 16'($urandom);
                if ($urandom_range(0, 7) != 0) addr_ixmem_p1[0] = 1'b0;
                st_data_ixmem_p1 = 16'($urandom);
                result_ixmem_p1  = 16'($urandom);
                rd_ixmem_p1      = 3'($urandom);
                reg_wr_ixmem_p1  = 1'($urandom_range(0, 1));
            end
            dmem_gnt_p1 = 1'b0; dmem_rvalid_p1 = 1'b0;
            if (m_busy && !m_granted) dmem_gnt_p1 = ($urandom_range(0, 2) == 0);
            if (m_busy && !m_store && (m_granted || dmem_gnt_p1))
                dmem_rvalid_p1 = ($urandom_range(0, 2) == 0);
            if (!m_busy && $urandom_range(0, 15) == 0) begin
                dmem_gnt_p1 = 1'b1; dmem_rvalid_p1 = 1'b1;
            end
            dmem_rdata_p1 = 16'($urandom);
            cycle_and_check("rand");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of execute; consumes the execute→memory (ixmem) bundle.
- Issues load/store transactions to an external data memory over a req/gnt/rvalid handshake.
- Passes non-memory results through unchanged.
- Drives a registered writeback bundle and stalls execute while a memory transaction is outstanding.

Parameters:
- DATA_W, 16, data/address width (uRISC word).
- TIMEOUT_CYC, 64, max cycles spent in REQ+WAIT before the transaction is abandoned with an error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_ixmem_p1  in  1  instruction present from execute
- ld_ixmem_p1  in  1  instruction is a load
- st_ixmem_p1  in  1  instruction is a store
- addr_ixmem_p1  in  DATA_W  effective address (ALU result)
- st_data_ixmem_p1  in  DATA_W  store data
- result_ixmem_p1  in  DATA_W  ALU result for non-memory ops
- rd_ixmem_p1  in  3  destination register
- reg_wr_ixmem_p1  in  1  instruction writes rd
- stall_memix_p1  out  1  execute must hold its bundle
- dmem_req_p1  out  1  memory request
- dmem_we_p1  out  1  1 = write
- dmem_addr_p1  out  DATA_W  request address
- dmem_wdata_p1  out  DATA_W  write data
- dmem_gnt_p1  in  1  request accepted
- dmem_rvalid_p1  in  1  read data valid
- dmem_rdata_p1  in  DATA_W  read data
- wb_valid_memwb_p1  out  1  writeback strobe, one cycle
- wb_rd_memwb_p1  out  3  writeback register
- wb_data_memwb_p1  out  DATA_W  writeback data
- err_p1  out  1  sticky error (misaligned or timeout)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All outputs 0: stall, dmem_*, wb_*, err_p1.
  - Timeout counter 0.
- Accept: bundle is consumed on a rising edge when valid_ixmem_p1=1 and stall_memix_p1=0. While stall is high, execute holds the bundle unchanged and it is not consumed.
- stall_memix_p1 = (state != IDLE); purely from registered state.
- ld and st both high is illegal: treat as error (err_p1 set), op dropped.
- Non-memory op (ld=st=0):
  - Next cycle: wb_valid = reg_wr, wb_rd = rd, wb_data = result.
  - Latency 1.
- Misaligned memory op (addr[0]=1):
  - err_p1 set; no dmem request; no writeback; state stays IDLE.
- FSM states IDLE, REQ, WAIT:
  - IDLE → REQ on aligned ld/st accept. Latch addr, wdata, we=st, rd, ld flag. Clear counter.
  - REQ:
    - dmem_req_p1=1 with stable addr/we/wdata until gnt.
    - Store: on gnt → IDLE; no writeback.
    - Load: on gnt → WAIT. If rvalid arrives in the same cycle as gnt → complete directly (IDLE, writeback).
  - WAIT:
    - dmem_req_p1=0.
    - On rvalid → IDLE; next cycle wb_valid=1, wb_rd=latched rd, wb_data=rdata.
- Load latency with gnt in the first REQ cycle and rvalid one cycle later: accept edge N, wb_valid visible after edge N+3.
- Timeout:
  - Counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYC-1 without completion: → IDLE, err_p1 set, no writeback.
  - A late rvalid/gnt arriving in IDLE is ignored.
- err_p1 is sticky until rst; the stage keeps processing subsequent instructions.
- wb_valid is a single-cycle pulse; wb_rd/wb_data hold their last value when wb_valid=0.
- rst mid-transaction: next cycle IDLE, dmem_req=0, any pending writeback discarded.

Decomposition:
- Shared package (urisc_pkg):
  - mem_state_t enum {IDLE, REQ, WAIT}.
  - DATA_W and REG_IDX_W=3 constants.
  - ixmem_bundle_t and memwb_bundle_t packed structs.
- One sub-module is natural: mem_timeout_cnt.
  - Inputs: clear, enable.
  - Output: expired.
  - Width $clog2(TIMEOUT_CYC).

Test Plan:
- ALU passthrough: valid, ld=st=0, result=0x1234, rd=3, reg_wr=1 → next cycle wb_valid=1, rd=3, data=0x1234; stall never high.
- Load, gnt delayed 2 cycles, rvalid 1 later with rdata=0xBEEF, addr=0x0040 → dmem_req held 3 cycles with addr 0x0040, we=0; stall high 4 cycles; wb_data=0xBEEF.
- Store addr=0x0010, data=0xA5A5, gnt immediate → one req cycle with we=1, wdata=0xA5A5; no wb_valid; stall high 1 cycle.
- Misaligned load addr=0x0011 → err_p1=1 next cycle, dmem_req never asserted; a following ALU op still writes back.
- No gnt for TIMEOUT_CYC cycles → return to IDLE, err_p1=1, no wb_valid; subsequent late rvalid ignored.
- rst asserted during WAIT → next cycle dmem_req=0, stall=0, wb_valid=0, err_p1=0.
